// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction cache.
// Bus command encoding, memory tag width, tag-array entry, miss FSM states.
package icache_pkg;

  localparam int XLEN      = 32;
  localparam int MEM_TAG_W = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  // Tag field is sized for the widest possible tag (IDX_W = 0).
  // Narrower tags are stored zero-extended, so the upper bits are constant.
  typedef struct packed {
    logic [XLEN-4:0] tags;
    logic            valid;
  } ICACHE_TAG_PACKET;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_REQ  = 2'd1,
    IC_WAIT = 2'd2
  } ICACHE_STATE;

endpackage

// File: rtl/icache_miss_ctrl.sv
// Miss handler: IDLE/REQ/WAIT FSM, pending line address and memory tag.
// Ports: clock/reset, i_miss, i_line (fetch line), i_mem_resp/i_mem_tag,
//        o_cmd/o_addr (memory request), o_fill_en/idx/tag, o_fill_cur.
import icache_pkg::*;

module icache_miss_ctrl #(
  parameter int IDX_W = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_miss,
  input  logic [XLEN-4:0]         i_line,
  input  logic [MEM_TAG_W-1:0]    i_mem_resp,
  input  logic [MEM_TAG_W-1:0]    i_mem_tag,
  output BUS_COMMAND              o_cmd,
  output logic [XLEN-1:0]         o_addr,
  output logic                    o_fill_en,
  output logic [IDX_W-1:0]        o_fill_idx,
  output logic [XLEN-4-IDX_W:0]   o_fill_tag,
  output logic                    o_fill_cur
);

  ICACHE_STATE          r_state;
  ICACHE_STATE          w_state_nxt;
  logic [XLEN-4:0]      r_pend_line;
  logic [XLEN-4:0]      w_line_nxt;
  logic [MEM_TAG_W-1:0] r_pend_tag;
  logic [MEM_TAG_W-1:0] w_tag_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IC_IDLE;
      r_pend_line <= '0;
      r_pend_tag  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_line <= w_line_nxt;
      r_pend_tag  <= w_tag_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_pend_line;
    w_tag_nxt   = r_pend_tag;
    o_cmd       = BUS_NONE;
    o_addr      = '0;
    o_fill_en   = 1'b0;
    unique case (r_state)
      IC_IDLE: begin
        if (i_miss) begin
          w_line_nxt  = i_line;
          w_state_nxt = IC_REQ;
        end
      end
      IC_REQ: begin
        o_cmd  = BUS_LOAD;
        o_addr = {r_pend_line, 3'b000};
        if (i_mem_resp != '0) begin
          w_tag_nxt   = i_mem_resp;
          w_state_nxt = IC_WAIT;
        end
      end
      IC_WAIT: begin
        // pend_tag of 0 never matches, so a stale return after reset is dropped.
        if ((r_pend_tag != '0) && (i_mem_tag == r_pend_tag)) begin
          o_fill_en   = 1'b1;
          w_tag_nxt   = '0;
          w_state_nxt = IC_IDLE;
        end
      end
      default: w_state_nxt = IC_IDLE;
    endcase
  end

  assign o_fill_idx = r_pend_line[IDX_W-1:0];
  assign o_fill_tag = r_pend_line[XLEN-4:IDX_W];
  assign o_fill_cur = o_fill_en && (i_line == r_pend_line);

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, 8-byte lines, one miss in flight.
// Ports: clock, reset, proc2Icache_addr -> Icache2proc_data/_valid (hit path);
//        proc2Imem_command/_addr, Imem2proc_response/_data/_tag (memory side).
// Optional macro ICACHE_FILL_BYPASS_EN forwards fill data in the return cycle.
import icache_pkg::*;

module icache #(
  parameter int CACHE_LINES = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [XLEN-1:0]      proc2Icache_addr,
  output logic [63:0]          Icache2proc_data,
  output logic                 Icache2proc_data_valid,
  output BUS_COMMAND           proc2Imem_command,
  output logic [XLEN-1:0]      proc2Imem_addr,
  input  logic [MEM_TAG_W-1:0] Imem2proc_response,
  input  logic [63:0]          Imem2proc_data,
  input  logic [MEM_TAG_W-1:0] Imem2proc_tag
);

  localparam int IDX_W = $clog2(CACHE_LINES);
  localparam int TAG_W = XLEN - 3 - IDX_W;

  ICACHE_TAG_PACKET r_tags [CACHE_LINES];
  logic [63:0]      r_data [CACHE_LINES];

  logic [XLEN-4:0]  w_line;
  logic [IDX_W-1:0] w_idx;
  logic [XLEN-4:0]  w_tag_x;
  logic             w_hit;
  logic             w_fill_en;
  logic [IDX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0] w_fill_tag;
  logic             w_fill_cur;
  logic             w_unused_ok;

  assign w_line  = proc2Icache_addr[XLEN-1:3];
  assign w_idx   = w_line[IDX_W-1:0];
  assign w_tag_x = {{IDX_W{1'b0}}, w_line[XLEN-4:IDX_W]};
  assign w_hit   = r_tags[w_idx].valid && (r_tags[w_idx].tags == w_tag_x);

  assign w_unused_ok = &{1'b0, proc2Icache_addr[2:0], w_fill_cur};

  icache_miss_ctrl #(
    .IDX_W(IDX_W)
  ) u_miss (
    .clock      (clock),
    .reset      (reset),
    .i_miss     (!w_hit),
    .i_line     (w_line),
    .i_mem_resp (Imem2proc_response),
    .i_mem_tag  (Imem2proc_tag),
    .o_cmd      (proc2Imem_command),
    .o_addr     (proc2Imem_addr),
    .o_fill_en  (w_fill_en),
    .o_fill_idx (w_fill_idx),
    .o_fill_tag (w_fill_tag),
    .o_fill_cur (w_fill_cur)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CACHE_LINES; i++) begin
        r_tags[i].valid <= 1'b0;
      end
    end else if (w_fill_en) begin
      r_tags[w_fill_idx].tags  <= {{IDX_W{1'b0}}, w_fill_tag};
      r_tags[w_fill_idx].valid <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_fill_en) begin
      r_data[w_fill_idx] <= Imem2proc_data;
    end
  end

  always_comb begin
    Icache2proc_data       = '0;
    Icache2proc_data_valid = 1'b0;
    if (w_hit) begin
      Icache2proc_data       = r_data[w_idx];
      Icache2proc_data_valid = 1'b1;
    end
`ifdef ICACHE_FILL_BYPASS_EN
    if (w_fill_cur) begin
      Icache2proc_data       = Imem2proc_data;
      Icache2proc_data_valid = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache.
// Vector table for fill/hit/backpressure/eviction, hand sequences for the rest.
import icache_pkg::*;

module tb_icache;

`ifdef ICACHE_FILL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset;
  logic [XLEN-1:0]      p_addr;
  logic [63:0]          c_data;
  logic                 c_valid;
  BUS_COMMAND           m_cmd;
  logic [XLEN-1:0]      m_addr;
  logic [MEM_TAG_W-1:0] m_resp;
  logic [63:0]          m_data;
  logic [MEM_TAG_W-1:0] m_tag;

  int errs   = 0;
  int checks = 0;

  always #5 clock = ~clock;

  icache dut (
    .clock                  (clock),
    .reset                  (reset),
    .proc2Icache_addr       (p_addr),
    .Icache2proc_data       (c_data),
    .Icache2proc_data_valid (c_valid),
    .proc2Imem_command      (m_cmd),
    .proc2Imem_addr         (m_addr),
    .Imem2proc_response     (m_resp),
    .Imem2proc_data         (m_data),
    .Imem2proc_tag          (m_tag)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] mdata;
    logic        ev;
    logic [63:0] ed;
    logic [1:0]  ecmd;
    logic [31:0] ema;
  } vec_t;

  vec_t vec [20];

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [63:0] D0 = 64'hDEAD_BEEF_0000_1111;
  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2 = 64'hAAAA_5555_0000_0100;
  localparam logic [63:0] D3 = 64'h4040_4040_4040_4040;
  localparam logic [63:0] D4 = 64'h0BAD_F00D_0000_0004;
  localparam logic [63:0] D5 = 64'h9999_0000_9999_0040;

  function automatic vec_t mk(input logic [31:0] a, input logic [3:0] r,
                              input logic [3:0] t, input logic [63:0] md,
                              input logic ev, input logic [63:0] ed,
                              input logic [1:0] ec, input logic [31:0] ema);
    vec_t v;
    v.addr = a; v.resp = r; v.tag = t; v.mdata = md;
    v.ev = ev; v.ed = ed; v.ecmd = ec; v.ema = ema;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input string nm, input logic [31:0] a,
                     input logic [3:0] r, input logic [3:0] t,
                     input logic [63:0] md, input logic ev,
                     input logic [63:0] ed, input logic [1:0] ec,
                     input logic [31:0] ema);
    p_addr = a; m_resp = r; m_tag = t; m_data = md;
    #3;
    chk({nm, ".valid"}, {63'd0, c_valid}, {63'd0, ev});
    chk({nm, ".data"}, c_data, ed);
    chk({nm, ".cmd"}, {62'd0, m_cmd}, {62'd0, ec});
    chk({nm, ".maddr"}, {32'd0, m_addr}, {32'd0, ema});
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; p_addr = '0; m_resp = '0; m_data = '0; m_tag = '0;

    vec[0]  = mk(32'h000, 0, 0, 0,  0, 0, NONE, 0);
    vec[1]  = mk(32'h000, 3, 0, 0,  0, 0, LOAD, 32'h000);
    vec[2]  = mk(32'h000, 0, 3, D0, BYP, BYP ? D0 : 64'd0, NONE, 0);
    vec[3]  = mk(32'h000, 0, 0, 0,  1, D0, NONE, 0);
    vec[4]  = mk(32'h004, 0, 0, 0,  1, D0, NONE, 0);
    vec[5]  = mk(32'h008, 0, 0, 0,  0, 0, NONE, 0);
    vec[6]  = mk(32'h008, 0, 0, 0,  0, 0, LOAD, 32'h008);
    vec[7]  = mk(32'h008, 0, 0, 0,  0, 0, LOAD, 32'h008);
    vec[8]  = mk(32'h008, 0, 0, 0,  0, 0, LOAD, 32'h008);
    vec[9]  = mk(32'h008, 0, 0, 0,  0, 0, LOAD, 32'h008);
    vec[10] = mk(32'h008, 5, 0, 0,  0, 0, LOAD, 32'h008);
    vec[11] = mk(32'h008, 0, 0, 0,  0, 0, NONE, 0);
    vec[12] = mk(32'h008, 0, 5, D1, BYP, BYP ? D1 : 64'd0, NONE, 0);
    vec[13] = mk(32'h00C, 0, 0, 0,  1, D1, NONE, 0);
    vec[14] = mk(32'h100, 0, 0, 0,  0, 0, NONE, 0);
    vec[15] = mk(32'h100, 1, 0, 0,  0, 0, LOAD, 32'h100);
    vec[16] = mk(32'h100, 0, 1, D2, BYP, BYP ? D2 : 64'd0, NONE, 0);
    vec[17] = mk(32'h104, 0, 0, 0,  1, D2, NONE, 0);
    vec[18] = mk(32'h000, 0, 0, 0,  0, 0, NONE, 0);
    vec[19] = mk(32'h000, 0, 0, 0,  0, 0, LOAD, 32'h000);

    // reset state
    tick();
    tick();
    #3;
    chk("rst.valid", {63'd0, c_valid}, 64'd0);
    chk("rst.data", c_data, 64'd0);
    chk("rst.cmd", {62'd0, m_cmd}, {62'd0, NONE});
    chk("rst.maddr", {32'd0, m_addr}, 64'd0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("v%0d", i), vec[i].addr, vec[i].resp, vec[i].tag,
          vec[i].mdata, vec[i].ev, vec[i].ed, vec[i].ecmd, vec[i].ema);
    end

    // redirect during a miss
    do_reset();
    cyc("rd.miss",   32'h040, 0, 0, 0,  0, 0, NONE, 0);
    cyc("rd.req",    32'h040, 2, 0, 0,  0, 0, LOAD, 32'h040);
    cyc("rd.tag7",   32'h080, 0, 7, D4, 0, 0, NONE, 0);
    cyc("rd.tag2",   32'h080, 0, 2, D3, 0, 0, NONE, 0);
    cyc("rd.miss80", 32'h080, 0, 0, 0,  0, 0, NONE, 0);
    cyc("rd.hit40",  32'h040, 0, 0, 0,  1, D3, LOAD, 32'h080);
    cyc("rd.req80",  32'h080, 6, 0, 0,  0, 0, LOAD, 32'h080);

    // reset while waiting on tag 4
    do_reset();
    cyc("rw.miss",   32'h040, 0, 0, 0,  0, 0, NONE, 0);
    cyc("rw.req",    32'h040, 4, 0, 0,  0, 0, LOAD, 32'h040);
    reset = 1'b1;
    p_addr = 32'h040; m_resp = '0; m_tag = '0;
    tick();
    reset = 1'b0;
    cyc("rw.stale",  32'h040, 0, 4, D4, 0, 0, NONE, 0);
    cyc("rw.stale2", 32'h040, 0, 4, D4, 0, 0, LOAD, 32'h040);
    cyc("rw.req9",   32'h040, 9, 0, 0,  0, 0, LOAD, 32'h040);
    cyc("rw.fill",   32'h040, 0, 9, D5, BYP, BYP ? D5 : 64'd0, NONE, 0);
    cyc("rw.hit",    32'h044, 0, 0, 0,  1, D5, NONE, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
